exc_arbiter: RTL and testbench

Parametrised next-generation exception/interrupt arbiter for the MIPS core's memory (commit) stage. It prioritises all exception sources, including TLB refill/invalid/modify for both fetch and data, and computes the ExcCode, EPC/BD, BadVAddr and handler vector from a programmable EBase. It drives a multi-channel pipeline flush, held by an explicit state machine until the front end confirms the redirected fetch. It also provides the CP0 write/clear-EXL strobes.

---
 rtl/exc_pkg.sv | 44 ++++
 rtl/exc_prio_enc.sv | 91 +++++++++
 rtl/exc_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_exc_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
// Shared types and constants for the commit-stage exception arbiter.
//   exc_code_e   : MIPS Cause.ExcCode values produced by the arbiter
//   arb_state_e  : flush-hold state machine encoding
//   badv_sel_e   : which address feeds BadVAddr (PC or data address)
//   DEFAULT_*    : default exception vector offsets from EBase
//   epc_value()  : EPC rule for instructions in a branch delay slot
// -----------------------------------------------------------------------------
package exc_pkg;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    typedef enum logic {
        BADV_PC   = 1'b0,
        BADV_DATA = 1'b1
    } badv_sel_e;

    localparam logic [31:0] DEFAULT_REFILL_OFFSET  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_GENERAL_OFFSET = 32'h0000_0180;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_value(input logic [31:0] pc_val,
                                              input logic       delay_slot);
        return delay_slot ? (pc_val - 32'd4) : pc_val;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// -----------------------------------------------------------------------------
// exc_prio_enc
// Purely combinational priority encoder over all exception sources.
// Inputs : int_req (already qualified interrupt), fetch faults, decode/execute
//          faults, data-side faults, data_we (store vs load), eret.
// Outputs: win            - any source present
//          code           - ExcCode of the highest-priority source
//          badvaddr_sel   - BadVAddr comes from PC or the data address
//          badvaddr_valid - winner is an address/TLB fault
//          is_refill      - winner is a TLB refill (selects refill vector)
//          is_eret        - winner is ERET (no exception entry)
// -----------------------------------------------------------------------------
import exc_pkg::*;

module exc_prio_enc (
    input  logic      int_req,
    input  logic      inst_adel,
    input  logic      inst_tlb_refill,
    input  logic      inst_tlb_invalid,
    input  logic      ri,
    input  logic      sys,
    input  logic      bp,
    input  logic      ov,
    input  logic      data_ade,
    input  logic      data_tlb_refill,
    input  logic      data_tlb_invalid,
    input  logic      data_mod,
    input  logic      data_we,
    input  logic      eret,
    output logic      win,
    output exc_code_e code,
    output badv_sel_e badvaddr_sel,
    output logic      badvaddr_valid,
    output logic      is_refill,
    output logic      is_eret
);

    // First matching source wins; ERET is the lowest priority event.
    always_comb begin
        win            = 1'b1;
        code           = EXC_INT;
        badvaddr_sel   = BADV_PC;
        badvaddr_valid = 1'b0;
        is_refill      = 1'b0;
        is_eret        = 1'b0;

        if (int_req) begin
            code = EXC_INT;
        end else if (inst_adel) begin
            code           = EXC_ADEL;
            badvaddr_valid = 1'b1;
        end else if (inst_tlb_refill) begin
            code           = EXC_TLBL;
            badvaddr_valid = 1'b1;
            is_refill      = 1'b1;
        end else if (inst_tlb_invalid) begin
            code           = EXC_TLBL;
            badvaddr_valid = 1'b1;
        end else if (ri) begin
            code = EXC_RI;
        end else if (sys) begin
            code = EXC_SYS;
        end else if (bp) begin
            code = EXC_BP;
        end else if (ov) begin
            code = EXC_OV;
        end else if (data_ade) begin
            code           = data_we ? EXC_ADES : EXC_ADEL;
            badvaddr_sel   = BADV_DATA;
            badvaddr_valid = 1'b1;
        end else if (data_tlb_refill) begin
            code           = data_we ? EXC_TLBS : EXC_TLBL;
            badvaddr_sel   = BADV_DATA;
            badvaddr_valid = 1'b1;
            is_refill      = 1'b1;
        end else if (data_tlb_invalid) begin
            code           = data_we ? EXC_TLBS : EXC_TLBL;
            badvaddr_sel   = BADV_DATA;
            badvaddr_valid = 1'b1;
        end else if (data_mod) begin
            code           = EXC_MOD;
            badvaddr_sel   = BADV_DATA;
            badvaddr_valid = 1'b1;
        end else if (eret) begin
            is_eret = 1'b1;
        end else begin
            win = 1'b0;
        end
    end

endmodule

// File: rtl/exc_arbiter.sv
// -----------------------------------------------------------------------------
// exc_arbiter
// Commit-stage exception/interrupt arbiter. Picks the highest-priority event,
// registers the CP0 update values and redirect target, and holds a
// multi-channel pipeline flush until the front end accepts the new fetch.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   int_pending/int_enable     - masked interrupt lines and global enable
//   exl_in, ebase_in           - Status.EXL and exception base
//   pc, in_delayslot           - committing instruction and its BD flag
//   data_vaddr, data_we        - data access address and direction
//   inst_*/ri/sys/bp/ov/data_* - exception sources
//   eret, cp0_epc              - ERET commit and its return target
//   fetch_done                 - redirected fetch accepted
//   flush                      - per-channel pipeline flush
//   new_pc                     - redirect target
//   exc_code/epc_out/bd_out    - Cause/EPC write values
//   badvaddr/badvaddr_we       - BadVAddr value and write strobe
//   cp0_wr_exp/clear_exl       - exception-entry and ERET strobes
//   current_exception          - combinational: any qualified event now
//   busy                       - flush hold in progress
// -----------------------------------------------------------------------------
import exc_pkg::*;

module exc_arbiter #(
    parameter int          NUM_INT        = 8,
    parameter int          NUM_FLUSH      = 4,
    parameter int          MIN_HOLD       = 1,
    parameter logic [31:0] REFILL_OFFSET  = DEFAULT_REFILL_OFFSET,
    parameter logic [31:0] GENERAL_OFFSET = DEFAULT_GENERAL_OFFSET
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_INT-1:0]   int_pending,
    input  logic                 int_enable,
    input  logic                 exl_in,
    input  logic [31:0]          ebase_in,
    input  logic [31:0]          pc,
    input  logic                 in_delayslot,
    input  logic [31:0]          data_vaddr,
    input  logic                 data_we,
    input  logic                 inst_adel,
    input  logic                 inst_tlb_refill,
    input  logic                 inst_tlb_invalid,
    input  logic                 ri,
    input  logic                 sys,
    input  logic                 bp,
    input  logic                 ov,
    input  logic                 data_ade,
    input  logic                 data_tlb_refill,
    input  logic                 data_tlb_invalid,
    input  logic                 data_mod,
    input  logic                 eret,
    input  logic [31:0]          cp0_epc,
    input  logic                 fetch_done,
    output logic [NUM_FLUSH-1:0] flush,
    output logic [31:0]          new_pc,
    output logic [4:0]           exc_code,
    output logic [31:0]          epc_out,
    output logic                 bd_out,
    output logic [31:0]          badvaddr,
    output logic                 badvaddr_we,
    output logic                 cp0_wr_exp,
    output logic                 clear_exl,
    output logic                 current_exception,
    output logic                 busy
);

    localparam int                CNT_W    = $clog2(MIN_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_SAT = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0]  HOLD_REL = CNT_W'(MIN_HOLD - 1);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             take_event;
    logic             rel_hold;

    logic             int_req;
    logic             win;
    exc_code_e        win_code;
    badv_sel_e        bv_sel;
    logic             bv_valid;
    logic             win_refill;
    logic             win_eret;
    logic [31:0]      vector;
    logic [31:0]      bv_value;

    assign int_req = int_enable & (|int_pending);

    exc_prio_enc u_prio (
        .int_req          (int_req),
        .inst_adel        (inst_adel),
        .inst_tlb_refill  (inst_tlb_refill),
        .inst_tlb_invalid (inst_tlb_invalid),
        .ri               (ri),
        .sys              (sys),
        .bp               (bp),
        .ov               (ov),
        .data_ade         (data_ade),
        .data_tlb_refill  (data_tlb_refill),
        .data_tlb_invalid (data_tlb_invalid),
        .data_mod         (data_mod),
        .data_we          (data_we),
        .eret             (eret),
        .win              (win),
        .code             (win_code),
        .badvaddr_sel     (bv_sel),
        .badvaddr_valid   (bv_valid),
        .is_refill        (win_refill),
        .is_eret          (win_eret)
    );

    assign current_exception = win;
    assign busy              = (state == HOLD);

    // Refill with EXL already set is a nested miss and goes to the general vector.
    assign vector   = (win_refill && !exl_in) ? (ebase_in + REFILL_OFFSET)
                                              : (ebase_in + GENERAL_OFFSET);
    assign bv_value = (bv_sel == BADV_DATA) ? data_vaddr : pc;

    // State register and saturating hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= cnt_next;
        end
    end

    // Next-state logic. Sources are only looked at in IDLE, or on the very
    // cycle the hold releases so a back-to-back event is not lost.
    always_comb begin
        state_next = state;
        cnt_next   = hold_cnt;
        take_event = 1'b0;
        rel_hold   = 1'b0;

        case (state)
            IDLE: begin
                if (win) begin
                    take_event = 1'b1;
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            HOLD: begin
                if (hold_cnt != HOLD_SAT) begin
                    cnt_next = hold_cnt + CNT_W'(1);
                end
                if ((hold_cnt >= HOLD_REL) && fetch_done) begin
                    if (win) begin
                        take_event = 1'b1;
                        state_next = HOLD;
                        cnt_next   = '0;
                    end else begin
                        rel_hold   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Registered outputs. EPC/BD are frozen while EXL is set; CP0 itself
    // guards the EXL update so cp0_wr_exp still pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush       <= '0;
            new_pc      <= '0;
            exc_code    <= '0;
            epc_out     <= '0;
            bd_out      <= 1'b0;
            badvaddr    <= '0;
            badvaddr_we <= 1'b0;
            cp0_wr_exp  <= 1'b0;
            clear_exl   <= 1'b0;
        end else begin
            badvaddr_we <= 1'b0;
            cp0_wr_exp  <= 1'b0;
            clear_exl   <= 1'b0;
            if (take_event) begin
                flush <= '1;
                if (win_eret) begin
                    new_pc    <= cp0_epc;
                    clear_exl <= 1'b1;
                end else begin
                    new_pc     <= vector;
                    exc_code   <= win_code;
                    cp0_wr_exp <= 1'b1;
                    if (!exl_in) begin
                        epc_out <= epc_value(pc, in_delayslot);
                        bd_out  <= in_delayslot;
                    end
                    if (bv_valid) begin
                        badvaddr    <= bv_value;
                        badvaddr_we <= 1'b1;
                    end
                end
            end else if (rel_hold) begin
                flush <= '0;
            end
        end
    end

endmodule

// File: tb/tb_exc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exc_arbiter
// Directed self-checking bench for exc_arbiter. Two instances share inputs:
// dut uses MIN_HOLD=1, dut3 uses MIN_HOLD=3 with its own fetch_done.
// -----------------------------------------------------------------------------
module tb_exc_arbiter;

    localparam logic [10:0] F_NONE  = 11'h000;
    localparam logic [10:0] F_ITLBR = 11'h200;
    localparam logic [10:0] F_SYS   = 11'h040;
    localparam logic [10:0] F_OV    = 11'h010;
    localparam logic [10:0] F_DTLBR = 11'h004;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  int_pending;
    logic        int_enable, exl_in, in_delayslot, data_we;
    logic [31:0] ebase_in, pc, data_vaddr, cp0_epc;
    logic        inst_adel, inst_tlb_refill, inst_tlb_invalid, ri, sys, bp, ov;
    logic        data_ade, data_tlb_refill, data_tlb_invalid, data_mod, eret;
    logic        fetch_done, fetch_done3;

    logic [3:0]  flush, flush3;
    logic [31:0] new_pc, new_pc3, epc_out, epc_out3, badvaddr, badvaddr3;
    logic [4:0]  exc_code, exc_code3;
    logic        bd_out, bd_out3, badvaddr_we, badvaddr_we3;
    logic        cp0_wr_exp, cp0_wr_exp3, clear_exl, clear_exl3;
    logic        current_exception, current_exception3, busy, busy3;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    exc_arbiter #(.MIN_HOLD(1)) dut (
        .clk(clk), .reset(reset), .int_pending(int_pending), .int_enable(int_enable),
        .exl_in(exl_in), .ebase_in(ebase_in), .pc(pc), .in_delayslot(in_delayslot),
        .data_vaddr(data_vaddr), .data_we(data_we), .inst_adel(inst_adel),
        .inst_tlb_refill(inst_tlb_refill), .inst_tlb_invalid(inst_tlb_invalid),
        .ri(ri), .sys(sys), .bp(bp), .ov(ov), .data_ade(data_ade),
        .data_tlb_refill(data_tlb_refill), .data_tlb_invalid(data_tlb_invalid),
        .data_mod(data_mod), .eret(eret), .cp0_epc(cp0_epc), .fetch_done(fetch_done),
        .flush(flush), .new_pc(new_pc), .exc_code(exc_code), .epc_out(epc_out),
        .bd_out(bd_out), .badvaddr(badvaddr), .badvaddr_we(badvaddr_we),
        .cp0_wr_exp(cp0_wr_exp), .clear_exl(clear_exl),
        .current_exception(current_exception), .busy(busy)
    );

    exc_arbiter #(.MIN_HOLD(3)) dut3 (
        .clk(clk), .reset(reset), .int_pending(int_pending), .int_enable(int_enable),
        .exl_in(exl_in), .ebase_in(ebase_in), .pc(pc), .in_delayslot(in_delayslot),
        .data_vaddr(data_vaddr), .data_we(data_we), .inst_adel(inst_adel),
        .inst_tlb_refill(inst_tlb_refill), .inst_tlb_invalid(inst_tlb_invalid),
        .ri(ri), .sys(sys), .bp(bp), .ov(ov), .data_ade(data_ade),
        .data_tlb_refill(data_tlb_refill), .data_tlb_invalid(data_tlb_invalid),
        .data_mod(data_mod), .eret(eret), .cp0_epc(cp0_epc), .fetch_done(fetch_done3),
        .flush(flush3), .new_pc(new_pc3), .exc_code(exc_code3), .epc_out(epc_out3),
        .bd_out(bd_out3), .badvaddr(badvaddr3), .badvaddr_we(badvaddr_we3),
        .cp0_wr_exp(cp0_wr_exp3), .clear_exl(clear_exl3),
        .current_exception(current_exception3), .busy(busy3)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives the fault sources (bit 10 inst_adel ... bit 0 data_mod) and eret.
    task automatic applyStimulus(input logic [10:0] faults, input logic do_eret);
        {inst_adel, inst_tlb_refill, inst_tlb_invalid, ri, sys, bp, ov,
         data_ade, data_tlb_refill, data_tlb_invalid, data_mod} = faults;
        eret = do_eret;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // With MIN_HOLD=1 a single fetch_done cycle releases the hold.
    task automatic releaseHold(input string tag);
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        checkOutput({tag, " flush released"}, 32'(flush), 32'h0);
        checkOutput({tag, " busy released"}, 32'(busy), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        int_pending = 8'h00; int_enable = 1'b0; exl_in = 1'b0;
        ebase_in = 32'hBFC0_0000; pc = 32'h0; in_delayslot = 1'b0;
        data_vaddr = 32'h0; data_we = 1'b0; cp0_epc = 32'h0;
        fetch_done = 1'b0; fetch_done3 = 1'b0;
        applyStimulus(F_NONE, 1'b0);
        tick();
        tick();

        // Reset state
        checkOutput("rst flush", 32'(flush), 32'h0);
        checkOutput("rst new_pc", new_pc, 32'h0);
        checkOutput("rst exc_code", 32'(exc_code), 32'h0);
        checkOutput("rst epc", epc_out, 32'h0);
        checkOutput("rst strobes", 32'({cp0_wr_exp, clear_exl, badvaddr_we, bd_out}), 32'h0);
        checkOutput("rst busy", 32'(busy), 32'h0);
        checkOutput("rst cur_exc", 32'(current_exception), 32'h0);
        reset = 1'b0;
        tick();

        // SYSCALL, not in delay slot
        pc = 32'h8000_1000;
        applyStimulus(F_SYS, 1'b0);
        #1;
        checkOutput("sys cur_exc", 32'(current_exception), 32'h1);
        tick();
        applyStimulus(F_NONE, 1'b0);
        checkOutput("sys flush", 32'(flush), 32'hF);
        checkOutput("sys code", 32'(exc_code), 32'd8);
        checkOutput("sys epc", epc_out, 32'h8000_1000);
        checkOutput("sys bd", 32'(bd_out), 32'h0);
        checkOutput("sys new_pc", new_pc, 32'hBFC0_0180);
        checkOutput("sys wr_exp", 32'(cp0_wr_exp), 32'h1);
        checkOutput("sys bv_we", 32'(badvaddr_we), 32'h0);
        checkOutput("sys busy", 32'(busy), 32'h1);
        // Event presented while holding without fetch_done is ignored
        applyStimulus(F_OV, 1'b0);
        tick();
        applyStimulus(F_NONE, 1'b0);
        checkOutput("hold wr_exp pulse", 32'(cp0_wr_exp), 32'h0);
        checkOutput("hold code kept", 32'(exc_code), 32'd8);
        checkOutput("hold flush", 32'(flush), 32'hF);
        releaseHold("sys");
        checkOutput("sys new_pc stable", new_pc, 32'hBFC0_0180);

        // Store TLB refill in delay slot, EXL=0 -> refill vector
        pc = 32'h8000_2008; in_delayslot = 1'b1;
        data_vaddr = 32'h0040_0004; data_we = 1'b1;
        applyStimulus(F_DTLBR, 1'b0);
        tick();
        applyStimulus(F_NONE, 1'b0);
        checkOutput("tlbs code", 32'(exc_code), 32'd3);
        checkOutput("tlbs badvaddr", badvaddr, 32'h0040_0004);
        checkOutput("tlbs bv_we", 32'(badvaddr_we), 32'h1);
        checkOutput("tlbs epc", epc_out, 32'h8000_2004);
        checkOutput("tlbs bd", 32'(bd_out), 32'h1);
        checkOutput("tlbs new_pc", new_pc, 32'hBFC0_0000);
        releaseHold("tlbs");

        // Same fault with EXL=1: general vector, EPC/BD frozen
        exl_in = 1'b1; pc = 32'h8000_5000; in_delayslot = 1'b0;
        applyStimulus(F_DTLBR, 1'b0);
        tick();
        applyStimulus(F_NONE, 1'b0);
        checkOutput("exl new_pc", new_pc, 32'hBFC0_0180);
        checkOutput("exl epc frozen", epc_out, 32'h8000_2004);
        checkOutput("exl bd frozen", 32'(bd_out), 32'h1);
        checkOutput("exl wr_exp", 32'(cp0_wr_exp), 32'h1);
        releaseHold("exl");
        exl_in = 1'b0; data_we = 1'b0;

        // Interrupt beats overflow
        pc = 32'h8000_1000;
        int_pending = 8'h04; int_enable = 1'b1;
        applyStimulus(F_OV, 1'b0);
        tick();
        applyStimulus(F_NONE, 1'b0);
        int_enable = 1'b0;
        checkOutput("int code", 32'(exc_code), 32'd0);
        checkOutput("int wr_exp", 32'(cp0_wr_exp), 32'h1);
        checkOutput("int bv_we", 32'(badvaddr_we), 32'h0);
        releaseHold("int");
        #1;
        checkOutput("masked int cur_exc", 32'(current_exception), 32'h0);
        applyStimulus(F_OV, 1'b0);
        tick();
        applyStimulus(F_NONE, 1'b0);
        checkOutput("ov code", 32'(exc_code), 32'd12);
        releaseHold("ov");
        int_pending = 8'h00;

        // ERET
        cp0_epc = 32'h8000_3000;
        applyStimulus(F_NONE, 1'b1);
        tick();
        applyStimulus(F_NONE, 1'b0);
        checkOutput("eret new_pc", new_pc, 32'h8000_3000);
        checkOutput("eret clear_exl", 32'(clear_exl), 32'h1);
        checkOutput("eret wr_exp", 32'(cp0_wr_exp), 32'h0);
        checkOutput("eret code kept", 32'(exc_code), 32'd12);
        checkOutput("eret flush", 32'(flush), 32'hF);
        tick();
        checkOutput("eret clear_exl pulse", 32'(clear_exl), 32'h0);
        tick();
        checkOutput("eret still held", 32'(flush), 32'hF);
        releaseHold("eret");

        // MIN_HOLD=3 with fetch_done held high: flush exactly three cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fetch_done3 = 1'b1;
        applyStimulus(F_SYS, 1'b0);
        tick();
        applyStimulus(F_NONE, 1'b0);
        checkOutput("mh3 c1 flush", 32'(flush3), 32'hF);
        tick();
        checkOutput("mh3 c2 flush", 32'(flush3), 32'hF);
        tick();
        checkOutput("mh3 c3 flush", 32'(flush3), 32'hF);
        tick();
        checkOutput("mh3 c4 flush", 32'(flush3), 32'h0);
        checkOutput("mh3 c4 busy", 32'(busy3), 32'h0);

        // MIN_HOLD=3: event on the release cycle is accepted back-to-back
        applyStimulus(F_SYS, 1'b0);
        tick();
        applyStimulus(F_NONE, 1'b0);
        tick();
        tick();
        data_vaddr = 32'h0000_1230; data_we = 1'b0;
        applyStimulus(F_DTLBR, 1'b0);
        tick();
        applyStimulus(F_NONE, 1'b0);
        checkOutput("b2b flush", 32'(flush3), 32'hF);
        checkOutput("b2b busy", 32'(busy3), 32'h1);
        checkOutput("b2b code", 32'(exc_code3), 32'd2);
        checkOutput("b2b new_pc", new_pc3, 32'hBFC0_0000);
        checkOutput("b2b wr_exp", 32'(cp0_wr_exp3), 32'h1);
        checkOutput("b2b badvaddr", badvaddr3, 32'h0000_1230);
        tick();
        checkOutput("b2b counter restarted", 32'(flush3), 32'hF);
        fetch_done3 = 1'b0;

        // Reset in the middle of a hold
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc = 32'h8000_4000;
        applyStimulus(F_ITLBR, 1'b0);
        tick();
        applyStimulus(F_NONE, 1'b0);
        checkOutput("itlb code", 32'(exc_code), 32'd2);
        checkOutput("itlb badvaddr", badvaddr, 32'h8000_4000);
        checkOutput("itlb new_pc", new_pc, 32'hBFC0_0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid rst flush", 32'(flush), 32'h0);
        checkOutput("mid rst busy", 32'(busy), 32'h0);
        checkOutput("mid rst new_pc", new_pc, 32'h0);
        checkOutput("mid rst code", 32'(exc_code), 32'h0);
        checkOutput("mid rst badvaddr", badvaddr, 32'h0);
        checkOutput("mid rst epc", epc_out, 32'h0);
        checkOutput("mid rst strobes", 32'({cp0_wr_exp, clear_exl, badvaddr_we, bd_out}), 32'h0);
        tick();
        checkOutput("mid rst stays idle", 32'(flush), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
